fp_issue_ctrl: RTL and testbench
================================

Name: fp_issue_ctrl

Overview:
- Parametrised issue/response controller in front of the FP sub-units: classifier, sign, comparator, converter, mul-add, div and sqrt.
- Latches one request's operands and drives them to the sub-units. Sequences fixed-latency units with a counter and variable-latency units (sqrt) with a done handshake.
- Holds the result under a valid/ready handshake, accumulates fflags, and supports flush.
- Supports FLEN 32 or 64; sits between decode/issue and the FP writeback stage.

Parameters:
- FLEN, 32, FP operand/result width (32 or 64).
- XLEN, 32, integer operand/result width.
- MULADD_LAT, 3, extra cycles for unit MulAdd (0..15).
- DIV_LAT, 10, extra cycles for unit Div (0..15).
- CVT_LAT, 1, extra cycles for unit Converter (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  abort the current operation
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_unit  in  3  0 Move, 1 Classifier, 2 Sign, 3 Comparator, 4 Converter, 5 MulAdd, 6 Div, 7 Sqrt
- req_rounding_mode  in  3  rounding mode
- req_int_src1  in  XLEN  integer operand
- req_fp_src1/2/3  in  FLEN each  FP operands
- op_unit, op_rounding_mode, op_int_src1, op_fp_src1/2/3  out  same widths  registered operands to the sub-units
- sub_enable  out  1  operation active
- sub_done  in  1  variable-latency completion (Sqrt only)
- sub_int_result  in  XLEN  muxed sub-unit integer result
- sub_fp_result  in  FLEN  muxed sub-unit FP result
- sub_write_flags  in  1  result carries flags
- sub_flags  in  5  NV DZ OF UF NX
- resp_valid  out  1  result held
- resp_ready  in  1  consumer takes result
- resp_int_result  out  XLEN  held integer result
- resp_fp_result  out  FLEN  held FP result
- resp_write_flags  out  1  held flag-write enable
- resp_flags  out  5  held flags
- fflags_clear  in  1  clear accrued flags
- fflags_accrued  out  5  sticky OR of retired flags

Behaviour:
- States: IDLE, BUSY, HOLD.
- Reset: state IDLE, all op_* 0, sub_enable 0, resp_valid 0, all resp_* 0, fflags_accrued 0, counter 0.
- req_ready = !flush && (state==IDLE || (state==HOLD && resp_ready)). This permits back-to-back issue with no bubble.
- Accept in cycle T:
  - Register op_*.
  - Load the counter with the unit's extra latency: MulAdd MULADD_LAT, Div DIV_LAT, Converter CVT_LAT, all others 0.
  - Go to BUSY.
- In HOLD, acceptance and retirement happen in the same cycle.
- BUSY:
  - sub_enable = 1.
  - Fixed units: while counter != 0, decrement. When counter == 0, capture sub_* into resp_* and go to HOLD.
  - Sqrt: ignore the counter; capture in the first BUSY cycle with sub_done = 1. No timeout.
  - Latency for a fixed unit with extra latency L: capture at end of cycle T+1+L; resp_valid rises in cycle T+2+L. Move/Classifier/Sign/Comparator therefore give resp_valid at T+2.
- HOLD:
  - resp_* stay stable while resp_valid && !resp_ready.
  - On resp_ready: retire. Go to IDLE, or to BUSY if a new request is accepted in the same cycle.
  - sub_enable = 0 in HOLD and IDLE.
- Accrued flags:
  - On retire with resp_write_flags = 1: fflags_accrued |= resp_flags.
  - fflags_clear alone clears the register.
  - fflags_clear in the same cycle as a retire: the register becomes resp_flags only (clear first, then OR).
- Flush (any state):
  - Next state IDLE; resp_valid and sub_enable go 0 next cycle; the counter is zeroed.
  - No request is accepted in the flush cycle.
  - A result held in HOLD is dropped and not retired, and its flags are not accrued, even if resp_ready = 1 in that cycle.
- Width: when FLEN=64 and XLEN=32, results pass through unmodified. Single-precision NaN-boxing is the sub-unit's responsibility.
- rst asserted mid-operation behaves as flush, and additionally clears fflags_accrued and op_*.

Test Plan:
- Comparator request at T, resp_ready=1, sub_flags=5'b10000, sub_write_flags=1 -> resp_valid in T+2 only; fflags_accrued=5'b10000 in T+3.
- MulAdd with MULADD_LAT=3, resp_ready=1 -> sub_enable high T+1..T+4; resp_valid at T+5; req_ready low T+1..T+4.
- Sqrt, sub_done pulsed at T+20 -> resp_fp_result equals the sub_fp_result sampled at T+20; resp_valid at T+21.
- Back-to-back: hold with resp_ready=0 for 3 cycles -> resp_* stable. Then resp_ready=1 with a new Sign request -> retire and accept in the same cycle; next resp_valid 2 cycles later.
- Flush during Div BUSY (counter=5) -> IDLE next cycle, no resp_valid, accrued flags unchanged. Flush in HOLD with resp_ready=1 -> no retire, flags not accrued.
- fflags_accrued=5'b00001; retire with flags 5'b00100 in the same cycle as fflags_clear -> fflags_accrued=5'b00100.

Source files
------------

// File: rtl/fp_issue_ctrl_if.sv
// Request/operand/sub-unit/response bundle between issue, fp_issue_ctrl and the FP sub-units.
// The controller uses the slave modport; the issuing side sees the master modport.
interface fp_issue_ctrl_if #(
  parameter int unsigned FLEN = 32,
  parameter int unsigned XLEN = 32
);
  // Request from decode/issue
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_unit;
  logic [2:0]      req_rounding_mode;
  logic [XLEN-1:0] req_int_src1;
  logic [FLEN-1:0] req_fp_src1;
  logic [FLEN-1:0] req_fp_src2;
  logic [FLEN-1:0] req_fp_src3;

  // Registered operands to the sub-units
  logic [2:0]      op_unit;
  logic [2:0]      op_rounding_mode;
  logic [XLEN-1:0] op_int_src1;
  logic [FLEN-1:0] op_fp_src1;
  logic [FLEN-1:0] op_fp_src2;
  logic [FLEN-1:0] op_fp_src3;

  // Sub-unit control and muxed results
  logic            sub_enable;
  logic            sub_done;
  logic [XLEN-1:0] sub_int_result;
  logic [FLEN-1:0] sub_fp_result;
  logic            sub_write_flags;
  logic [4:0]      sub_flags;

  // Held response towards writeback
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_int_result;
  logic [FLEN-1:0] resp_fp_result;
  logic            resp_write_flags;
  logic [4:0]      resp_flags;

  modport slave (
    input  req_valid, req_unit, req_rounding_mode, req_int_src1,
           req_fp_src1, req_fp_src2, req_fp_src3,
    output req_ready,
    output op_unit, op_rounding_mode, op_int_src1, op_fp_src1, op_fp_src2, op_fp_src3,
    output sub_enable,
    input  sub_done, sub_int_result, sub_fp_result, sub_write_flags, sub_flags,
    output resp_valid, resp_int_result, resp_fp_result, resp_write_flags, resp_flags,
    input  resp_ready
  );

  modport master (
    output req_valid, req_unit, req_rounding_mode, req_int_src1,
           req_fp_src1, req_fp_src2, req_fp_src3,
    input  req_ready,
    input  op_unit, op_rounding_mode, op_int_src1, op_fp_src1, op_fp_src2, op_fp_src3,
    input  sub_enable,
    output sub_done, sub_int_result, sub_fp_result, sub_write_flags, sub_flags,
    input  resp_valid, resp_int_result, resp_fp_result, resp_write_flags, resp_flags,
    output resp_ready
  );
endinterface

// File: rtl/fp_issue_ctrl.sv
// Issue/response controller for the FP sub-units: latches one request, sequences fixed or
// handshake latency, holds the result under valid/ready and accrues retired fflags.
module fp_issue_ctrl #(
  parameter int unsigned FLEN       = 32,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MULADD_LAT = 3,
  parameter int unsigned DIV_LAT    = 10,
  parameter int unsigned CVT_LAT    = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               fflags_clear_i,
  output logic [4:0]         fflags_accrued_o,
  fp_issue_ctrl_if.slave     bus
);

  localparam logic [2:0] UnitCvt    = 3'd4;
  localparam logic [2:0] UnitMulAdd = 3'd5;
  localparam logic [2:0] UnitDiv    = 3'd6;
  localparam logic [2:0] UnitSqrt   = 3'd7;

  typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      req_lat;

  logic [2:0]      unit_q;
  logic [2:0]      rm_q;
  logic [XLEN-1:0] int_src1_q;
  logic [FLEN-1:0] fp_src1_q, fp_src2_q, fp_src3_q;

  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_int_q;
  logic [FLEN-1:0] resp_fp_q;
  logic            resp_wf_q;
  logic [4:0]      resp_flags_q;
  logic [4:0]      acc_q, acc_d;

  logic            accept, capture, retire;

  assign bus.req_ready = !flush_i &&
                         ((state_q == StIdle) || ((state_q == StHold) && bus.resp_ready));
  assign accept  = bus.req_valid && bus.req_ready;
  assign retire  = (state_q == StHold) && bus.resp_ready && !flush_i;
  // Sqrt finishes on its own done strobe; every other unit finishes when the counter drains.
  assign capture = (state_q == StBusy) && !flush_i &&
                   ((unit_q == UnitSqrt) ? bus.sub_done : (cnt_q == 4'd0));

  always_comb begin
    req_lat = 4'd0;
    case (bus.req_unit)
      UnitMulAdd: req_lat = 4'(MULADD_LAT);
      UnitDiv:    req_lat = 4'(DIV_LAT);
      UnitCvt:    req_lat = 4'(CVT_LAT);
      default:    req_lat = 4'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StBusy;
      StBusy: begin
        if (capture) begin
          state_d = StHold;
        end else if ((unit_q != UnitSqrt) && (cnt_q != 4'd0)) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: if (retire) state_d = accept ? StBusy : StIdle;
      default: state_d = StIdle;
    endcase
    if (accept) cnt_d = req_lat;
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
    end
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    if (retire)  resp_valid_d = 1'b0;
    if (capture) resp_valid_d = 1'b1;
    if (flush_i) resp_valid_d = 1'b0;
  end

  // Clear takes effect before the retiring flags are merged in.
  always_comb begin
    acc_d = fflags_clear_i ? 5'd0 : acc_q;
    if (retire && resp_wf_q) acc_d = acc_d | resp_flags_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      acc_q        <= 5'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      acc_q        <= acc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      unit_q     <= 3'd0;
      rm_q       <= 3'd0;
      int_src1_q <= '0;
      fp_src1_q  <= '0;
      fp_src2_q  <= '0;
      fp_src3_q  <= '0;
    end else if (accept) begin
      unit_q     <= bus.req_unit;
      rm_q       <= bus.req_rounding_mode;
      int_src1_q <= bus.req_int_src1;
      fp_src1_q  <= bus.req_fp_src1;
      fp_src2_q  <= bus.req_fp_src2;
      fp_src3_q  <= bus.req_fp_src3;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_int_q   <= '0;
      resp_fp_q    <= '0;
      resp_wf_q    <= 1'b0;
      resp_flags_q <= 5'd0;
    end else if (capture) begin
      resp_int_q   <= bus.sub_int_result;
      resp_fp_q    <= bus.sub_fp_result;
      resp_wf_q    <= bus.sub_write_flags;
      resp_flags_q <= bus.sub_flags;
    end
  end

  assign bus.op_unit          = unit_q;
  assign bus.op_rounding_mode = rm_q;
  assign bus.op_int_src1      = int_src1_q;
  assign bus.op_fp_src1       = fp_src1_q;
  assign bus.op_fp_src2       = fp_src2_q;
  assign bus.op_fp_src3       = fp_src3_q;
  assign bus.sub_enable       = (state_q == StBusy);

  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_int_result  = resp_int_q;
  assign bus.resp_fp_result   = resp_fp_q;
  assign bus.resp_write_flags = resp_wf_q;
  assign bus.resp_flags       = resp_flags_q;
  assign fflags_accrued_o     = acc_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Bench for fp_issue_ctrl: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a timestamp-based transaction model.
module tb_fp_issue_ctrl;
  localparam int unsigned FL = 64;
  localparam int unsigned XL = 32;
  localparam int unsigned LMA = 3;
  localparam int unsigned LDIV = 10;
  localparam int unsigned LCVT = 1;

  logic clk = 1'b0;
  logic rst, flush, fclr;
  logic [4:0] facc;

  fp_issue_ctrl_if #(.FLEN(FL), .XLEN(XL)) bus ();

  fp_issue_ctrl #(
    .FLEN(FL), .XLEN(XL), .MULADD_LAT(LMA), .DIV_LAT(LDIV), .CVT_LAT(LCVT)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .fflags_clear_i   (fclr),
    .fflags_accrued_o (facc),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: one in-flight op with a known finish cycle, one held result, sticky flags.
  bit            m_live = 1'b0;
  bit            m_busy, m_held;
  logic [2:0]    m_unit, m_rm;
  logic [XL-1:0] m_int;
  logic [FL-1:0] m_f1, m_f2, m_f3;
  int            m_done_at;
  logic [XL-1:0] m_rint;
  logic [FL-1:0] m_rfp;
  logic          m_rwf;
  logic [4:0]    m_rfl, m_acc;

  function automatic int lat_of(input logic [2:0] u);
    case (u)
      3'd4:    return int'(LCVT);
      3'd5:    return int'(LMA);
      3'd6:    return int'(LDIV);
      default: return 0;
    endcase
  endfunction

  function automatic bit exp_rr();
    return !flush && !m_busy && (!m_held || bus.resp_ready);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare();
    if (!m_live) return;
    chk("req_ready", bus.req_ready, exp_rr());
    chk("sub_enable", bus.sub_enable, m_busy);
    chk("resp_valid", bus.resp_valid, m_held);
    chk("resp_int", bus.resp_int_result, m_rint);
    chk("resp_fp", bus.resp_fp_result, m_rfp);
    chk("resp_wf", bus.resp_write_flags, m_rwf);
    chk("resp_flags", bus.resp_flags, m_rfl);
    chk("fflags_acc", facc, m_acc);
    chk("op_unit", bus.op_unit, m_unit);
    chk("op_rm", bus.op_rounding_mode, m_rm);
    chk("op_int", bus.op_int_src1, m_int);
    chk("op_fp1", bus.op_fp_src1, m_f1);
    chk("op_fp2", bus.op_fp_src2, m_f2);
    chk("op_fp3", bus.op_fp_src3, m_f3);
  endtask

  task automatic model_update();
    bit acc_ok, ret, cap;
    if (rst) begin
      m_live = 1'b1; m_busy = 0; m_held = 0;
      m_unit = '0; m_rm = '0; m_int = '0; m_f1 = '0; m_f2 = '0; m_f3 = '0;
      m_rint = '0; m_rfp = '0; m_rwf = 0; m_rfl = '0; m_acc = '0;
    end else if (m_live) begin
      acc_ok = bus.req_valid && exp_rr();
      if (flush) begin
        m_busy = 0; m_held = 0;
        if (fclr) m_acc = '0;
      end else begin
        ret = m_held && bus.resp_ready;
        cap = m_busy && ((m_unit == 3'd7) ? bus.sub_done : (cyc == m_done_at));
        if (fclr) m_acc = '0;
        if (ret && m_rwf) m_acc = m_acc | m_rfl;
        if (ret) m_held = 0;
        if (cap) begin
          m_held = 1; m_busy = 0;
          m_rint = bus.sub_int_result; m_rfp = bus.sub_fp_result;
          m_rwf = bus.sub_write_flags; m_rfl = bus.sub_flags;
        end
        if (acc_ok) begin
          m_busy = 1; m_unit = bus.req_unit; m_rm = bus.req_rounding_mode;
          m_int = bus.req_int_src1; m_f1 = bus.req_fp_src1; m_f2 = bus.req_fp_src2;
          m_f3 = bus.req_fp_src3; m_done_at = cyc + 1 + lat_of(bus.req_unit);
        end
      end
    end
  endtask

  task automatic drive(input bit v, input logic [2:0] u, input bit rr, input bit fl,
                       input bit clr, input bit done, input bit wf, input logic [4:0] flg);
    rst = 1'b0; flush = fl; fclr = clr;
    bus.req_valid = v; bus.req_unit = u; bus.req_rounding_mode = 3'($urandom);
    bus.req_int_src1 = $urandom;
    bus.req_fp_src1 = {$urandom, $urandom};
    bus.req_fp_src2 = {$urandom, $urandom};
    bus.req_fp_src3 = {$urandom, $urandom};
    bus.resp_ready = rr; bus.sub_done = done;
    bus.sub_int_result = $urandom; bus.sub_fp_result = {$urandom, $urandom};
    bus.sub_write_flags = wf; bus.sub_flags = flg;
  endtask

  task automatic sample();
    @(negedge clk);
    compare();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [FL-1:0] fp_save;

  initial begin
    drive(0, 3'd0, 0, 0, 0, 0, 0, 5'd0);
    rst = 1'b1;
    repeat (2) begin sample(); advance(); end
    drive(0, 3'd0, 0, 0, 0, 0, 0, 5'd0);
    sample();
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_sub_enable", bus.sub_enable, 0);
    chk("rst_acc", facc, 0);
    chk("rst_op_fp1", bus.op_fp_src1, 0);
    advance();

    // Comparator: resp_valid only in T+2, flags accrued in T+3
    drive(1, 3'd3, 1, 0, 0, 0, 1, 5'b10000); sample();
    chk("cmp_accept", bus.req_ready, 1); advance();
    drive(0, 3'd0, 1, 0, 0, 0, 1, 5'b10000); sample();
    chk("cmp_t1_valid", bus.resp_valid, 0); advance();
    sample();
    chk("cmp_t2_valid", bus.resp_valid, 1);
    chk("cmp_t2_flags", bus.resp_flags, 5'b10000); advance();
    sample();
    chk("cmp_t3_valid", bus.resp_valid, 0);
    chk("cmp_t3_acc", facc, 5'b10000); advance();

    // MulAdd, 3 extra cycles: busy T+1..T+4, valid at T+5
    drive(1, 3'd5, 1, 0, 0, 0, 0, 5'd0); sample(); advance();
    drive(0, 3'd0, 1, 0, 0, 0, 0, 5'd0);
    for (int i = 1; i <= 4; i++) begin
      sample();
      chk("ma_sub_enable", bus.sub_enable, 1);
      chk("ma_req_ready", bus.req_ready, 0);
      advance();
    end
    sample();
    chk("ma_t5_valid", bus.resp_valid, 1);
    chk("ma_t5_sub_enable", bus.sub_enable, 0); advance();
    sample(); advance();

    // Clear in the retire cycle leaves only the retiring flags
    for (int k = 0; k < 2; k++) begin
      logic [4:0] flg;
      flg = (k == 0) ? 5'b00001 : 5'b00100;
      drive(1, 3'd2, 1, 0, 0, 0, 1, flg); sample(); advance();
      drive(0, 3'd0, 1, 0, 0, 0, 1, flg); sample(); advance();
      drive(0, 3'd0, 1, 0, 1, 0, 1, flg); sample();
      chk("clr_ret_valid", bus.resp_valid, 1); advance();
      drive(0, 3'd0, 1, 0, 0, 0, 1, flg); sample();
      chk("clr_ret_acc", facc, flg); advance();
    end

    // Held result stable for 3 cycles, then retire and accept back-to-back
    drive(1, 3'd2, 0, 0, 0, 0, 0, 5'd0); sample(); advance();
    drive(0, 3'd0, 0, 0, 0, 0, 0, 5'd0); fp_save = bus.sub_fp_result; sample(); advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 3'd0, 0, 0, 0, 0, 0, 5'd0); sample();
      chk("hold_valid", bus.resp_valid, 1);
      chk("hold_fp", bus.resp_fp_result, fp_save);
      advance();
    end
    drive(1, 3'd2, 1, 0, 0, 0, 0, 5'd0); sample();
    chk("b2b_req_ready", bus.req_ready, 1); advance();
    drive(0, 3'd0, 1, 0, 0, 0, 0, 5'd0); sample();
    chk("b2b_t1_valid", bus.resp_valid, 0);
    chk("b2b_t1_busy", bus.sub_enable, 1); advance();
    sample();
    chk("b2b_t2_valid", bus.resp_valid, 1); advance();

    // Sqrt completes on sub_done at T+20
    drive(1, 3'd7, 1, 0, 0, 0, 0, 5'd0); sample(); advance();
    for (int i = 1; i <= 20; i++) begin
      drive(0, 3'd0, 1, 0, 0, (i == 20), 0, 5'd0);
      if (i == 20) fp_save = bus.sub_fp_result;
      sample();
      chk("sqrt_wait_valid", bus.resp_valid, 0);
      advance();
    end
    drive(0, 3'd0, 1, 0, 0, 0, 0, 5'd0); sample();
    chk("sqrt_valid", bus.resp_valid, 1);
    chk("sqrt_fp", bus.resp_fp_result, fp_save); advance();

    // Flush Div at counter 5, then flush a held result while resp_ready is high
    drive(1, 3'd6, 1, 0, 0, 0, 1, 5'b11111); sample(); advance();
    for (int i = 1; i <= 5; i++) begin
      drive(0, 3'd0, 1, 0, 0, 0, 1, 5'b11111); sample(); advance();
    end
    drive(0, 3'd0, 1, 1, 0, 0, 1, 5'b11111); sample();
    chk("div_flush_rr", bus.req_ready, 0); advance();
    for (int i = 0; i < 7; i++) begin
      drive(0, 3'd0, 1, 0, 0, 0, 1, 5'b11111); sample();
      chk("div_flush_valid", bus.resp_valid, 0);
      chk("div_flush_busy", bus.sub_enable, 0);
      chk("div_flush_acc", facc, 5'b00100);
      advance();
    end
    drive(1, 3'd1, 0, 0, 0, 0, 1, 5'b01000); sample(); advance();
    drive(0, 3'd0, 0, 0, 0, 0, 1, 5'b01000); sample(); advance();
    drive(0, 3'd0, 1, 1, 0, 0, 1, 5'b01000); sample();
    chk("hold_flush_pre", bus.resp_valid, 1); advance();
    drive(0, 3'd0, 1, 0, 0, 0, 0, 5'd0); sample();
    chk("hold_flush_valid", bus.resp_valid, 0);
    chk("hold_flush_acc", facc, 5'b00100); advance();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) < 60, 3'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 25,
            1'($urandom), 5'($urandom));
      rst = ($urandom_range(0, 999) < 5);
      sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
